pwm_multi_channel: RTL

Multi-channel, parametrised PWM generator for servo/motor and LED drive.
- One shared prescaler and period counter; each channel compares its own duty value against the counter.
- Duty values are written through a valid/ready port into shadow registers and take effect only at a period boundary, giving glitch-free updates.
- Outputs are registered. The block replaces single-channel fixed-window PWM instances.

---
 rtl/pwm_multi_channel.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel
// Multi-channel PWM generator. One shared prescaler and period counter; each
// channel compares its active duty against the counter. Duty writes land in
// shadow registers through a valid/ready port and are committed to the active
// set at the period wrap, or continuously while the block is disabled.
// Optional build macro: PWM_PHASE_STAGGER_EN staggers each channel's compare
// phase by i * (2^RES_BITS / CHANNELS) ticks to spread rising edges.
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int RES_BITS = 10,
  parameter int PRESCALE = 2,
  localparam int CHAN_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [CHAN_BITS-1:0] wr_chan,
  input  logic [RES_BITS:0]    wr_duty,
  output logic                 wr_err,
  output logic [CHANNELS-1:0]  signal,
  output logic                 period_start
);

  localparam int                  PS_BITS    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_BITS-1:0]  PS_LAST    = PS_BITS'(PRESCALE - 1);
  localparam logic [RES_BITS-1:0] CNT_LAST   = '1;
  localparam logic [RES_BITS:0]   DUTY_FULL  = {1'b1, {RES_BITS{1'b0}}};
  localparam logic [CHAN_BITS:0]  CHAN_LIMIT = (CHAN_BITS + 1)'(CHANNELS);
`ifdef PWM_PHASE_STAGGER_EN
  localparam int                  PHASE_OFF  = (2 ** RES_BITS) / CHANNELS;
`endif

  logic [PS_BITS-1:0]  prescaler;
  logic [RES_BITS-1:0] cnt;
  logic [RES_BITS:0]   shadow      [CHANNELS];
  logic [RES_BITS:0]   shadow_next [CHANNELS];
  logic [RES_BITS:0]   active      [CHANNELS];
  logic [RES_BITS-1:0] cmp_cnt     [CHANNELS];
  logic [CHANNELS-1:0] hi;
  logic                tick;
  logic                commit;
  logic                wr_fire;
  logic                chan_ok;
  logic [RES_BITS:0]   duty_clamped;

  assign tick         = (prescaler == PS_LAST);
  assign commit       = enable && tick && (cnt == CNT_LAST);
  assign wr_fire      = wr_valid && wr_ready;
  assign chan_ok      = ({1'b0, wr_chan} < CHAN_LIMIT);
  assign duty_clamped = (wr_duty > DUTY_FULL) ? DUTY_FULL : wr_duty;

  // Write port is ready from the first clock edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ready <= 1'b0;
    end else begin
      wr_ready <= 1'b1;
    end
  end

  // Shared prescaler and period counter; both parked at zero while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      cnt       <= '0;
    end else if (!enable) begin
      prescaler <= '0;
      cnt       <= '0;
    end else if (tick) begin
      prescaler <= '0;
      cnt       <= cnt + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Shadow contents after this cycle's write; also feeds the commit bypass
  // so a write accepted in the commit cycle reaches the coming period.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      shadow_next[i] = shadow[i];
      if (wr_fire && chan_ok && (wr_chan == CHAN_BITS'(i))) begin
        shadow_next[i] = duty_clamped;
      end
    end
  end

  // Shadow capture every cycle; active duty follows shadow at the wrap tick
  // or continuously while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow[i] <= shadow_next[i];
        if (!enable || commit) begin
          active[i] <= shadow_next[i];
        end
      end
    end
  end

  // Per-channel compare; a full-scale duty always exceeds the counter range.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
      cmp_cnt[i] = cnt - RES_BITS'(i * PHASE_OFF);
`else
      cmp_cnt[i] = cnt;
`endif
      hi[i] = ({1'b0, cmp_cnt[i]} < active[i]);
    end
  end

  // Registered outputs: PWM levels, period marker and write-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signal       <= '0;
      period_start <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      signal       <= enable ? hi : '0;
      period_start <= enable && (cnt == '0) && (prescaler == '0);
      wr_err       <= wr_fire && !chan_ok;
    end
  end

endmodule
